float8_mult: RTL and testbench

Signed 8-bit minifloat multiplier used by the TPU datapath to form weight × activation products for the DNN digit classifier. It takes two operands in the team's 1-3-4 format (sign, exponent, mantissa) and returns their product in the same format. Mantissas are truncated and the result saturates at the format limits. The product is registered, so the output appears one clock after the operands.

---
 rtl/float8_mult_if.sv | 10 +
 rtl/float8_mult.sv | 43 ++++
 tb/tb_float8_mult.sv | 113 +++++++++++
 3 files changed

// File: rtl/float8_mult_if.sv
// Operand/product bundle for the 1-3-4 minifloat multiplier.
// Clock and reset stay as plain ports on the multiplier itself.
interface float8_mult_if;
  logic [7:0] iNum1;
  logic [7:0] iNum2;
  logic [7:0] oNum;

  modport master (output iNum1, output iNum2, input oNum);
  modport slave  (input iNum1, input iNum2, output oNum);
endinterface

// File: rtl/float8_mult.sv
// Signed 1-3-4 minifloat multiplier (bias 4, no denormals) with a registered product.
// Mantissa is truncated and the exponent saturates high / flushes to zero low.
module float8_mult (
  input  logic        iClk,
  input  logic        iRst,
  float8_mult_if.slave bus
);
  localparam logic [7:0] ZERO  = 8'h00;
  localparam logic [7:0] UNITY = 8'h80;

  logic              sign;
  logic [9:0]        prod;
  logic signed [5:0] expSum;
  logic [3:0]        mant;
  logic [7:0]        nextNum;

  always_comb begin
    sign    = bus.iNum1[7] ^ bus.iNum2[7];
    prod    = {5'b0, 1'b1, bus.iNum1[3:0]} * {5'b0, 1'b1, bus.iNum2[3:0]};
    // Unbiased sum plus one when the significand product lands in [2,4).
    expSum  = $signed({3'b0, bus.iNum1[6:4]}) + $signed({3'b0, bus.iNum2[6:4]})
              + $signed({5'b0, prod[9]}) - 6'sd4;
    mant    = prod[9] ? prod[8:5] : prod[7:4];
    nextNum = ZERO;
    if (bus.iNum1 == ZERO || bus.iNum2 == ZERO)
      nextNum = ZERO;
    else if (bus.iNum1 == UNITY)
      nextNum = bus.iNum2;
    else if (bus.iNum2 == UNITY)
      nextNum = bus.iNum1;
    else if (expSum > 6'sd7)
      nextNum = {sign, 7'h7F};
    else if (expSum < 6'sd0)
      nextNum = ZERO;  // sign dropped too, so underflow never aliases unity
    else
      nextNum = {sign, expSum[2:0], mant};
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) bus.oNum <= ZERO;
    else      bus.oNum <= nextNum;
  end
endmodule

// File: tb/tb_float8_mult.sv
// Bench for float8_mult: directed literal vectors, reset behaviour and random
// pairs checked every cycle against a real-arithmetic model of the format.
module tb_float8_mult;
  logic iClk = 1'b0;
  logic iRst = 1'b1;
  float8_mult_if bus ();

  float8_mult dut (.iClk(iClk), .iRst(iRst), .bus(bus.slave));

  always #5 iClk = ~iClk;

  int checks = 0;
  int fails  = 0;
  logic [7:0] expNum = 8'h00;

  function automatic real codeMag(input logic [7:0] c);
    real v;
    v = (16.0 + real'(c[3:0])) / 16.0;
    for (int k = 0; k < 4; k++) v = v / 2.0;
    for (int k = 0; k < int'(c[6:4]); k++) v = v * 2.0;
    return v;
  endfunction

  function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b);
    real mag;
    int  ex, m;
    logic s;
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    if (a == 8'h80) return b;
    if (b == 8'h80) return a;
    s   = a[7] ^ b[7];
    mag = codeMag(a) * codeMag(b);
    ex  = 0;
    while (mag >= 2.0) begin mag = mag / 2.0; ex++; end
    while (mag < 1.0)  begin mag = mag * 2.0; ex--; end
    ex = ex + 4;
    if (ex > 7) return {s, 7'h7F};
    if (ex < 0) return 8'h00;
    m = $rtoi((mag - 1.0) * 16.0);
    return {s, ex[2:0], m[3:0]};
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Expected register content, tracked the way the spec describes it.
  always @(posedge iClk) expNum <= iRst ? 8'h00 : model(bus.iNum1, bus.iNum2);
  always @(posedge iRst) expNum <= 8'h00;

  always @(negedge iClk) check("cycle", bus.oNum, expNum);

  task automatic vec(input logic [7:0] a, input logic [7:0] b, input logic [7:0] want);
    @(negedge iClk);
    bus.iNum1 = a;
    bus.iNum2 = b;
    check($sformatf("model %h*%h", a, b), model(a, b), want);
    @(posedge iClk);
    #1 check($sformatf("dut %h*%h", a, b), bus.oNum, want);
  endtask

  initial begin
    bus.iNum1 = 8'h00;
    bus.iNum2 = 8'h00;
    #2 check("reset state", bus.oNum, 8'h00);
    repeat (2) @(negedge iClk);
    iRst = 1'b0;

    vec(8'h1D, 8'h2C, 8'h09);
    vec(8'h38, 8'hB8, 8'hB2);
    vec(8'h43, 8'hA3, 8'hA6);
    vec(8'h20, 8'hB5, 8'h95);
    vec(8'h20, 8'hB8, 8'h98);
    vec(8'h40, 8'hB8, 8'hB8);
    vec(8'h00, 8'hB3, 8'h00);
    vec(8'h7F, 8'h80, 8'h7F);
    vec(8'h80, 8'hA3, 8'hA3);
    vec(8'h80, 8'h80, 8'h80);
    vec(8'h00, 8'h80, 8'h00);
    vec(8'h7F, 8'h3F, 8'h7E);
    vec(8'h7F, 8'h7F, 8'h7F);
    vec(8'hFF, 8'h7F, 8'hFF);
    vec(8'h01, 8'h01, 8'h00);
    vec(8'h81, 8'h01, 8'h00);

    // Asynchronous reset between edges, then recovery on the next edge.
    vec(8'h38, 8'h38, 8'h32);
    #1 iRst = 1'b1;
    #1 check("async reset", bus.oNum, 8'h00);
    repeat (2) begin
      @(posedge iClk);
      #1 check("held in reset", bus.oNum, 8'h00);
    end
    @(negedge iClk);
    iRst = 1'b0;
    @(posedge iClk);
    #1 check("after reset", bus.oNum, 8'h32);

    for (int i = 0; i < 10000; i++) begin
      @(negedge iClk);
      bus.iNum1 = 8'($urandom);
      bus.iNum2 = 8'($urandom);
    end
    @(negedge iClk);
    @(negedge iClk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
